// File: rtl/dmem_responder_if.sv
// Request/response bus between the core's load/store path and dmem_responder.
// Handshake: a transfer occurs on a rising clk edge where valid and ready are both high;
// the sender holds its payload stable from raising valid until that edge.
interface dmem_responder_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/dmem_responder.sv
// Word-organised data memory serving RV32I loads/stores with byte-lane merging and extension.
// Define DMEM_MISALIGN_EN to allow misaligned (including word-spanning) accesses.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256
) (
   input  logic            clk,
   input  logic            reset,
   dmem_responder_if.slave bus,
   output logic [1:0]      dbg_state
);
   localparam int AW = $clog2(DEPTH_WORDS);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WORD0 = 2'd1;
   localparam logic [1:0] WORD1 = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   logic [1:0]    state_q, state_d;
   logic          we_q, we_d;
   logic [2:0]    funct3_q, funct3_d;
   logic [AW+1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [31:0]   ld_q, ld_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q, rsp_err_d;

   logic [31:0]   mem [DEPTH_WORDS];

   logic [2:0]    size;
   logic [1:0]    off;
   logic          legal_f3;
   logic          misalign_bad;
   logic          spans;
   logic          dec_err;
   logic [AW-1:0] w0, w1, mem_idx;
   logic [31:0]   rd_word;
   logic [31:0]   mem_wdata;
   logic [3:0]    mem_be;
   logic          mem_we;
   logic          lane_active;
   logic [1:0]    kb;
   logic [31:0]   ext_data;
   logic          unused_addr_hi;

   assign unused_addr_hi = ^bus.req_addr[31:AW+2];

   // Decode of the latched request; stays valid from WORD0 through RESP.
   always_comb begin
      size = 3'd4;
      case (funct3_q[1:0])
         2'b00:   size = 3'd1;
         2'b01:   size = 3'd2;
         default: size = 3'd4;
      endcase
      off = addr_q[1:0];
      if (we_q) legal_f3 = (funct3_q == 3'b000) || (funct3_q == 3'b001) || (funct3_q == 3'b010);
      else      legal_f3 = (funct3_q == 3'b000) || (funct3_q == 3'b001) || (funct3_q == 3'b010) ||
                           (funct3_q == 3'b100) || (funct3_q == 3'b101);
`ifdef DMEM_MISALIGN_EN
      misalign_bad = 1'b0;
`else
      misalign_bad = ((size == 3'd2) && off[0]) || ((size == 3'd4) && (off != 2'b00));
`endif
      spans   = ({2'b00, off} + {1'b0, size}) > 4'd4;
      dec_err = !legal_f3 || misalign_bad;
      w0      = addr_q[AW+1:2];
      w1      = w0 + 1'b1;
      mem_idx = (state_q == WORD1) ? w1 : w0;
      rd_word = mem[mem_idx];
   end

   always_comb begin
      case (funct3_q)
         3'b000:  ext_data = {{24{ld_q[7]}}, ld_q[7:0]};
         3'b001:  ext_data = {{16{ld_q[15]}}, ld_q[15:0]};
         3'b100:  ext_data = {24'h0, ld_q[7:0]};
         3'b101:  ext_data = {16'h0, ld_q[15:0]};
         default: ext_data = ld_q;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      we_d        = we_q;
      funct3_d    = funct3_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      ld_d        = ld_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      mem_be      = 4'b0000;
      mem_wdata   = 32'h0;
      kb          = 2'b00;
      lane_active = ((state_q == WORD0) && !dec_err) || (state_q == WORD1);

      // Lane l of the current word carries access byte k; WORD1 continues where WORD0 stopped.
      for (int l = 0; l < 4; l++) begin
         int k;
         k = (state_q == WORD1) ? (l + 4 - int'(off)) : (l - int'(off));
         if (lane_active && (k >= 0) && (k < int'(size))) begin
            kb                 = k[1:0];
            mem_be[l]          = 1'b1;
            mem_wdata[8*l +: 8] = wdata_q[{kb, 3'b000} +: 8];
            if (!we_q) ld_d[{kb, 3'b000} +: 8] = rd_word[8*l +: 8];
         end
      end
      mem_we = lane_active && we_q && !reset;

      case (state_q)
         IDLE: begin
            if (bus.req_valid) begin
               we_d     = bus.req_we;
               funct3_d = bus.req_funct3;
               addr_d   = bus.req_addr[AW+1:0];
               wdata_d  = bus.req_wdata;
               ld_d     = 32'h0;
               state_d  = WORD0;
            end
         end
         WORD0: begin
            if (dec_err)    state_d = RESP;
            else if (spans) state_d = WORD1;
            else            state_d = RESP;
         end
         WORD1: state_d = RESP;
         default: begin
            // First RESP cycle registers the response; it is then held until accepted.
            if (!rsp_valid_q) begin
               rsp_valid_d = 1'b1;
               rsp_err_d   = dec_err;
               rsp_rdata_d = (dec_err || we_q) ? 32'h0 : ext_data;
            end else if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         we_q        <= 1'b0;
         funct3_q    <= 3'b000;
         addr_q      <= '0;
         wdata_q     <= 32'h0;
         ld_q        <= 32'h0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         we_q        <= we_d;
         funct3_q    <= funct3_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         ld_q        <= ld_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_be[i]) mem[mem_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
         end
      end
   end

   assign bus.req_ready = (state_q == IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign dbg_state     = state_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: store/load merging, extension, errors, latency, hold and reset.
// Extra checks apply when DMEM_MISALIGN_EN is defined.
module tb_dmem_responder;
   localparam int DEPTH = 256;
   localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_W = 3'b010, F_BU = 3'b100, F_HU = 3'b101;
   localparam logic [1:0] S_IDLE = 2'd0, S_WORD0 = 2'd1, S_WORD1 = 2'd2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  dbg_state;
   int          total = 0;
   int          bad = 0;
   logic [31:0] exp_q[$];

   dmem_responder_if bus();

   dmem_responder #(.DEPTH_WORDS(DEPTH)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // Clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected test end");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Driver tasks
   task automatic send(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata);
      @(negedge clk);
      check("req_ready_idle", 32'(bus.req_ready), 32'd1);
      bus.req_valid  = 1'b1;
      bus.req_we     = we;
      bus.req_funct3 = f3;
      bus.req_addr   = addr;
      bus.req_wdata  = wdata;
      @(posedge clk);
      #1;
      bus.req_valid  = 1'b0;
   endtask

   task automatic wait_rsp(input string tag, input int exp_lat);
      int lat;
      lat = 0;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!bus.rsp_valid && lat < 20);
      check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
   endtask

   task automatic finish_rsp(input string tag, input logic exp_err);
      logic [31:0] e;
      e = exp_q.pop_front();
      check({tag, "_rdata"}, bus.rsp_rdata, e);
      check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      check({tag, "_rsp_drop"}, 32'(bus.rsp_valid), 32'd0);
   endtask

   task automatic xact(input string tag, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
      exp_q.push_back(exp_rdata);
      send(we, f3, addr, wdata);
      wait_rsp(tag, exp_lat);
      finish_rsp(tag, exp_err);
   endtask

   initial begin
      bus.req_valid  = 1'b0;
      bus.req_we     = 1'b0;
      bus.req_funct3 = 3'b000;
      bus.req_addr   = 32'h0;
      bus.req_wdata  = 32'h0;
      bus.rsp_ready  = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      check("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
      check("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check("rst_state", 32'(dbg_state), 32'(S_IDLE));

      xact("sw0", 1'b1, F_W, 32'h0, 32'habcde4ef, 32'h0, 1'b0, 2);

      // Confirm the request moved into WORD0 on the accept edge
      exp_q.push_back(32'habcde4ef);
      send(1'b0, F_W, 32'h0, 32'h0);
      check("lw0_state_word0", 32'(dbg_state), 32'(S_WORD0));
      check("lw0_req_ready_busy", 32'(bus.req_ready), 32'd0);
      wait_rsp("lw0", 2);
      finish_rsp("lw0", 1'b0);

      xact("lh0",  1'b0, F_H,  32'h0, 32'h0, 32'hffffe4ef, 1'b0, 2);
      xact("lhu0", 1'b0, F_HU, 32'h0, 32'h0, 32'h0000e4ef, 1'b0, 2);
      xact("lb0",  1'b0, F_B,  32'h0, 32'h0, 32'hffffffef, 1'b0, 2);
      xact("lbu0", 1'b0, F_BU, 32'h0, 32'h0, 32'h000000ef, 1'b0, 2);
      xact("lbu3", 1'b0, F_BU, 32'h3, 32'h0, 32'h000000ab, 1'b0, 2);

      xact("sb2",     1'b1, F_B, 32'h2, 32'h00000012, 32'h0, 1'b0, 2);
      xact("lw_sb2",  1'b0, F_W, 32'h0, 32'h0, 32'hab12e4ef, 1'b0, 2);
      xact("sh0",     1'b1, F_H, 32'h0, 32'h00005555, 32'h0, 1'b0, 2);
      xact("lw_sh0",  1'b0, F_W, 32'h0, 32'h0, 32'hab125555, 1'b0, 2);
      xact("lh2_neg", 1'b0, F_H, 32'h2, 32'h0, 32'hffffab12, 1'b0, 2);

      xact("sw4_zero", 1'b1, F_W, 32'h4, 32'h0, 32'h0, 1'b0, 2);
      xact("sw8_zero", 1'b1, F_W, 32'h8, 32'h0, 32'h0, 1'b0, 2);

`ifdef DMEM_MISALIGN_EN
      xact("sw6_span", 1'b1, F_W, 32'h6, 32'h11223344, 32'h0, 1'b0, 3);
      xact("lw4_span", 1'b0, F_W, 32'h4, 32'h0, 32'h33440000, 1'b0, 2);
      xact("lw8_span", 1'b0, F_W, 32'h8, 32'h0, 32'h00001122, 1'b0, 2);
      xact("lw6_span", 1'b0, F_W, 32'h6, 32'h0, 32'h11223344, 1'b0, 3);
      xact("lh1_mis",  1'b0, F_H, 32'h1, 32'h0, 32'h00001255, 1'b0, 2);
`else
      xact("sw6_err",  1'b1, F_W, 32'h6, 32'h11223344, 32'h0, 1'b1, 2);
      xact("lw4_keep", 1'b0, F_W, 32'h4, 32'h0, 32'h0, 1'b0, 2);
      xact("lw8_keep", 1'b0, F_W, 32'h8, 32'h0, 32'h0, 1'b0, 2);
      xact("lh1_err",  1'b0, F_H, 32'h1, 32'h0, 32'h0, 1'b1, 2);
      xact("sh1_err",  1'b1, F_H, 32'h1, 32'hffffffff, 32'h0, 1'b1, 2);
      xact("lw2_err",  1'b0, F_W, 32'h2, 32'h0, 32'h0, 1'b1, 2);
      xact("lw0_keep", 1'b0, F_W, 32'h0, 32'h0, 32'hab125555, 1'b0, 2);
`endif

      xact("sbu_store_err", 1'b1, F_BU, 32'h0, 32'hffffffff, 32'h0, 1'b1, 2);
      xact("lw0_after_err", 1'b0, F_W, 32'h0, 32'h0, 32'hab125555, 1'b0, 2);

      // Illegal funct3 with the consumer stalling for three cycles
      exp_q.push_back(32'h0);
      send(1'b0, 3'b011, 32'h0, 32'h0);
      wait_rsp("ill", 2);
      for (int i = 0; i < 3; i++) begin
         check("ill_hold_valid", 32'(bus.rsp_valid), 32'd1);
         check("ill_hold_err", 32'(bus.rsp_err), 32'd1);
         check("ill_hold_rdata", bus.rsp_rdata, 32'h0);
         check("ill_hold_req_ready", 32'(bus.req_ready), 32'd0);
         @(posedge clk);
         @(negedge clk);
      end
      finish_rsp("ill", 1'b1);
      check("ill_req_ready_after", 32'(bus.req_ready), 32'd1);

`ifdef DMEM_MISALIGN_EN
      // Wrapping spanning store cut off by reset while in WORD1
      xact("sw_last", 1'b1, F_W, 32'h3fc, 32'ha1a2a3a4, 32'h0, 1'b0, 2);
      send(1'b1, F_W, 32'(4 * DEPTH - 2), 32'hdeadbeef);
      @(posedge clk);
      #1;
      check("wrap_state_word1", 32'(dbg_state), 32'(S_WORD1));
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
      check("mid_rst_rdata", bus.rsp_rdata, 32'h0);
      check("mid_rst_err", 32'(bus.rsp_err), 32'd0);
      check("mid_rst_state", 32'(dbg_state), 32'(S_IDLE));
      repeat (3) begin
         @(negedge clk);
         check("mid_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
      end
      xact("lw_last_after", 1'b0, F_W, 32'h3fc, 32'h0, 32'hbeefa3a4, 1'b0, 2);
      xact("lw_w0_after",   1'b0, F_W, 32'h0,   32'h0, 32'hab125555, 1'b0, 2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
